mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//   Shares the single-port 2K x 16 node data memory between NUM_REQ engines
//   (reward, Q-update, packet RX/TX). Each engine gets exclusive access for a burst.
//   Engines are served round-robin. The hold-time watchdog preempts any engine that
//   keeps the memory too long while others wait. Sits between the engines and the
//   memory macro; engines drive address/data only while granted.
// PARAMETERS
//   NUM_REQ    4    number of requesters, 2..8
//   ADDR_WIDTH 11   memory word address width
//   WORD_WIDTH 16   memory data width
//   MAX_HOLD   64   max grant cycles before preemption if another req pending (>=2)
// PORTS
//   clock      in   1                     single clock, rising edge
//   rst        in   1                     asynchronous, active-high reset
//   req        in   NUM_REQ               per-engine access request, level, hold for burst
//   req_addr   in   NUM_REQ*ADDR_WIDTH    flattened addresses, slice i = engine i
//   req_wdata  in   NUM_REQ*WORD_WIDTH    flattened write data
//   req_we     in   NUM_REQ               per-engine write enable
//   gnt        out  NUM_REQ               one-hot grant, registered
//   rvalid     out  NUM_REQ               read data valid for engine i, registered
//   rdata      out  WORD_WIDTH            mem_rdata broadcast to all engines
//   preempt    out  1                     1-cycle pulse when watchdog revokes a grant
//   mem_addr   out  ADDR_WIDTH            to memory
//   mem_wdata  out  WORD_WIDTH            to memory
//   mem_we     out  1                     to memory
//   mem_rdata  in   WORD_WIDTH            from memory, 1-cycle synchronous read latency
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, gnt=0, rvalid=0, preempt=0, hold_cnt=0,
//     last=NUM_REQ-1, so engine 0 has top priority first.
//   mem_addr/mem_wdata are 0 and mem_we=0 whenever gnt==0.
//   FSM IDLE: if any req, pick the first set bit searching last+1, last+2 ... (wrap mod NUM_REQ).
//     Next cycle: gnt[sel]=1, owner=sel, last=sel, hold_cnt=1, state=GRANT. Min req->gnt latency 1.
//   FSM GRANT: mem_addr=req_addr[owner], mem_wdata=req_wdata[owner], mem_we=req_we[owner]
//     (combinational from registered owner; no gating beyond gnt).
//     - req[owner]=0: gnt cleared next cycle.
//       If another req is set this cycle, re-arbitrate now (owner excluded by rotation);
//       the next gnt rises one cycle after gnt falls, giving exactly one idle bus cycle.
//       Otherwise go to IDLE.
//     - hold_cnt==MAX_HOLD and any other req set: gnt[owner] cleared next cycle,
//       preempt=1 for that cycle, then arbitrate as on release. The preempted engine
//       keeps req high and is re-served in rotation order.
//     - hold_cnt==MAX_HOLD with no other req: no preemption, hold_cnt saturates.
//     - otherwise hold_cnt++ (saturating at MAX_HOLD).
//   rvalid[i]=1 in cycle t+1 iff gnt[i]=1 and req_we[i]=0 in cycle t. The read issued in
//     the last granted cycle is still reported. rdata = mem_rdata, unregistered.
//   req_we with no grant has no effect. Deasserting req of a non-owner has no effect.
//   Simultaneous release by owner and new req by same engine: the engine loses priority
//     to any other pending requester (fairness); if alone, it is re-granted after the gap.
//   Reset mid-burst: grant dropped the same cycle; a pending memory write in that
//     cycle is not guaranteed.
// TESTING
//   1. Reset, req=0001 at t0 -> gnt=0001 at t1; addr 0x148 write 0x00AB lands in memory.
//   2. req=1111 held, each engine 3-cycle burst -> grant order 0,1,2,3,0; 1 idle cycle between.
//   3. Engine 2 reads addr 0x1C8 (mem holds 0x1234) -> rvalid=0100, rdata=0x1234 next cycle.
//   4. Engine 1 holds with engine 3 pending, MAX_HOLD=64 -> gnt[1] drops after 64 cycles,
//      preempt pulse, gnt=1000 one cycle later.
//   5. Engine 0 alone holds 200 cycles -> no preempt, hold_cnt saturates, gnt stays 0001.
//   6. Assert rst during engine 3 burst -> gnt=0, rvalid=0 at once; after release, req=1001 -> engine 0 first.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port memory between NUM_REQ engines,
// with a hold-time watchdog that preempts a long burst when another engine is waiting.
module mem_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 11,
    parameter int WORD_WIDTH = 16,
    parameter int MAX_HOLD   = 64
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]            req_we,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [WORD_WIDTH-1:0]         rdata,
    output logic                          preempt,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [WORD_WIDTH-1:0]         mem_wdata,
    output logic                          mem_we,
    input  logic [WORD_WIDTH-1:0]         mem_rdata
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
    state_t state;
    logic [OW-1:0] owner, last, sel;
    logic [HW-1:0] hold_cnt;
    logic          found, others, busy;
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && req[(int'(last) + i) % NUM_REQ]) begin
                found = 1'b1;
                sel   = OW'((int'(last) + i) % NUM_REQ);
            end
        end
    end
    assign others    = |(req & ~(NUM_REQ'(1) << owner));
    assign busy      = |gnt;
    assign mem_addr  = busy ? req_addr[owner*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign mem_wdata = busy ? req_wdata[owner*WORD_WIDTH +: WORD_WIDTH] : '0;
    assign mem_we    = busy & req_we[owner];
    assign rdata     = mem_rdata;
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            rvalid   <= '0;
            preempt  <= 1'b0;
            hold_cnt <= '0;
            owner    <= '0;
            last     <= OW'(NUM_REQ - 1);
        end else begin
            rvalid  <= gnt & ~req_we;
            preempt <= 1'b0;
            case (state)
                IDLE: if (found) begin
                    state    <= GRANT;
                    owner    <= sel;
                    last     <= sel;
                    gnt      <= NUM_REQ'(1) << sel;
                    hold_cnt <= HW'(1);
                end
                GRANT: if (!req[owner] || (hold_cnt == HW'(MAX_HOLD) && others)) begin
                    // Next owner is chosen now; it is granted after one idle bus cycle.
                    gnt      <= '0;
                    hold_cnt <= '0;
                    preempt  <= req[owner];
                    state    <= others ? GAP : IDLE;
                    if (others) begin
                        owner <= sel;
                        last  <= sel;
                    end
                end else begin
                    hold_cnt <= hold_cnt + HW'(hold_cnt != HW'(MAX_HOLD));
                end
                default: begin
                    state    <= GRANT;
                    gnt      <= NUM_REQ'(1) << owner;
                    hold_cnt <= HW'(1);
                end
            endcase
        end
    end
endmodule
